// File: rtl/spi_flash_responder.sv
// SPI-flash responder (mode 0, single-bit I/O).
// Oversamples the SPI pins on clk_i, decodes a small JEDEC-style command set
// and serves READ/PROG/STATUS/JEDEC traffic from an internal byte array.
module spi_flash_responder #(
  parameter int          MemBytes = 256,
  parameter logic [23:0] JedecId  = 24'hEF4016
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sck_i,
  input  logic                        cs_ni,
  input  logic                        copi_i,
  output logic                        cipo_o,
  output logic                        cipo_en_o,
  output logic                        wel_o,
  input  logic                        load_en_i,
  input  logic [$clog2(MemBytes)-1:0] load_addr_i,
  input  logic [7:0]                  load_data_i
);

  localparam int AW = $clog2(MemBytes);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_STATUS, S_JEDEC, S_IGNORE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_en_next;

  logic            r_sck_s1, r_sck_s2, r_sck_d;
  logic            r_cs_s1, r_cs_s2;
  logic            r_copi_s1, r_copi_s2;

  logic [2:0]      r_bitcnt;
  logic [6:0]      r_shift;
  logic [7:0]      r_tx;
  logic            r_cipo;
  logic            r_cipo_en;
  logic            r_wel;
  logic            r_prog_wel;
  logic            r_is_read;
  logic [1:0]      r_addr_cnt;
  logic [1:0]      r_jcnt;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_mem [MemBytes];

  logic            w_rise, w_fall, w_cs;
  logic [7:0]      w_byte;
  logic            w_done;
  logic [AW-1:0]   w_addr_full;
  logic            w_prog_we;
  logic [7:0]      w_status;

  assign w_rise      = r_sck_s2 & ~r_sck_d;
  assign w_fall      = ~r_sck_s2 & r_sck_d;
  assign w_cs        = r_cs_s2;
  assign w_byte      = {r_shift, r_copi_s2};
  assign w_done      = w_rise & ~w_cs & (r_bitcnt == 3'd7);
  assign w_addr_full = AW'({r_addr, w_byte});
  assign w_prog_we   = w_done & (r_state == S_PROG) & r_wel & ~rst_i;
  assign w_status    = {6'b0, r_wel, 1'b0};

  assign cipo_o    = r_cipo;
  assign cipo_en_o = r_cipo_en;
  assign wel_o     = r_wel;

  // Two-flop synchronizers plus the sck delay register used for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_copi_s1 <= 1'b0;
      r_copi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= sck_i;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_cs_s1   <= cs_ni;
      r_cs_s2   <= r_cs_s1;
      r_copi_s1 <= copi_i;
      r_copi_s2 <= r_copi_s1;
    end
  end

  // Protocol state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode on completed bytes; cs high always wins.
  always_comb begin
    w_state_next = r_state;
    w_en_next    = 1'b0;
    if (w_cs) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_CMD;
        S_CMD: begin
          if (w_done) begin
            case (w_byte)
              8'h03, 8'h02: w_state_next = S_ADDR;
              8'h05:        w_state_next = S_STATUS;
              8'h9F:        w_state_next = S_JEDEC;
              default:      w_state_next = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (w_done && r_addr_cnt == 2'd2)
            w_state_next = r_is_read ? S_READ : S_PROG;
        end
        default: w_state_next = r_state;
      endcase
    end
    w_en_next = (w_state_next == S_READ) || (w_state_next == S_STATUS) ||
                (w_state_next == S_JEDEC);
  end

  // Bit/byte datapath: receive shift, response loading, address and WEL tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bitcnt   <= 3'd0;
      r_cipo     <= 1'b0;
      r_cipo_en  <= 1'b0;
      r_wel      <= 1'b0;
      r_prog_wel <= 1'b0;
      r_is_read  <= 1'b0;
      r_addr_cnt <= 2'd0;
      r_jcnt     <= 2'd0;
    end else begin
      r_cipo_en <= w_en_next;
      if (!w_en_next)  r_cipo <= 1'b0;
      else if (w_fall) r_cipo <= r_tx[7];
      if (w_fall) r_tx <= {r_tx[6:0], 1'b0};

      if (w_cs) begin
        r_bitcnt   <= 3'd0;
        r_addr_cnt <= 2'd0;
        if (r_prog_wel) begin
          r_wel      <= 1'b0;
          r_prog_wel <= 1'b0;
        end
      end else if (w_rise) begin
        r_shift  <= w_byte[6:0];
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if (w_done) begin
        case (r_state)
          S_CMD: begin
            r_addr_cnt <= 2'd0;
            case (w_byte)
              8'h03: r_is_read <= 1'b1;
              8'h02: r_is_read <= 1'b0;
              8'h05: r_tx <= w_status;
              8'h9F: begin
                r_tx   <= JedecId[23:16];
                r_jcnt <= 2'd1;
              end
              8'h06: r_wel <= 1'b1;
              8'h04: r_wel <= 1'b0;
              default: ;
            endcase
          end
          S_ADDR: begin
            r_addr_cnt <= r_addr_cnt + 2'd1;
            if (r_addr_cnt == 2'd2) begin
              if (r_is_read) begin
                r_tx   <= r_mem[w_addr_full];
                r_addr <= w_addr_full + AW'(1);
              end else begin
                r_addr     <= w_addr_full;
                r_prog_wel <= r_wel;
              end
            end else begin
              r_addr <= w_addr_full;
            end
          end
          S_READ: begin
            r_tx   <= r_mem[r_addr];
            r_addr <= r_addr + AW'(1);
          end
          S_PROG: begin
            if (r_wel) r_addr <= r_addr + AW'(1);
          end
          S_STATUS: r_tx <= w_status;
          S_JEDEC: begin
            case (r_jcnt)
              2'd1: begin
                r_tx   <= JedecId[15:8];
                r_jcnt <= 2'd2;
              end
              2'd2: begin
                r_tx   <= JedecId[7:0];
                r_jcnt <= 2'd3;
              end
              default: r_tx <= 8'hFF;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Byte array: program writes first, so a coincident backdoor load wins.
  always_ff @(posedge clk_i) begin
    if (w_prog_we) r_mem[r_addr] <= w_byte;
    if (load_en_i) r_mem[load_addr_i] <= load_data_i;
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: directed vector table, hand-built corner
// sequences, then random transactions checked against a transaction-level model.
module tb_spi_flash_responder;

  localparam int MB = 256;

  typedef logic [0:7][7:0] bytes8_t;
  typedef struct {
    string   name;
    bytes8_t tx;
    int      n;
    bytes8_t rx;
    logic [7:0] en;
    logic    wel;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, sck, cs_n, copi;
  logic       cipo, cipo_en, wel;
  logic       load_en;
  logic [7:0] load_addr, load_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_mem [MB];
  logic       m_wel;

  always #5 clk = ~clk;

  spi_flash_responder #(.MemBytes(MB), .JedecId(24'hEF4016)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .cs_ni(cs_n), .copi_i(copi),
    .cipo_o(cipo), .cipo_en_o(cipo_en), .wel_o(wel),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %02h expected %02h", nm, idx, act, exp);
  endtask

  // Shift nbits of b (MSB first), sampling cipo/cipo_en at each host rise.
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx,
                          output logic en_any, output logic en_all);
    rx = 8'h00; en_any = 1'b0; en_all = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      copi = b[7-k];
      repeat (6) @(negedge clk);
      rx[7-k] = cipo;
      en_any  = en_any | cipo_en;
      en_all  = en_all & cipo_en;
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic do_txn(input bytes8_t tx, input int n, output bytes8_t rx,
                        output logic [7:0] ea, output logic [7:0] eall);
    logic a, b;
    logic [7:0] r;
    rx = '0; ea = '0; eall = '0;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spi_bits(tx[i], 8, r, a, b);
      rx[i] = r; ea[i] = a; eall[i] = b;
    end
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Transaction-level model: expected reply bytes and enables for a whole cs-low frame.
  task automatic model_txn(input bytes8_t tx, input int n, output bytes8_t exp_rx,
                           output logic [7:0] exp_en);
    logic [23:0] jid;
    int unsigned a;
    jid = 24'hEF4016;
    exp_rx = '0; exp_en = '0;
    if (n == 0) return;
    case (tx[0])
      8'h9F: for (int i = 1; i < n; i++) begin
        exp_en[i] = 1'b1;
        exp_rx[i] = (i <= 3) ? jid[8*(3-i) +: 8] : 8'hFF;
      end
      8'h05: for (int i = 1; i < n; i++) begin
        exp_en[i] = 1'b1;
        exp_rx[i] = {6'b0, m_wel, 1'b0};
      end
      8'h06: m_wel = 1'b1;
      8'h04: m_wel = 1'b0;
      8'h03: if (n > 4) begin
        a = {8'h00, tx[1], tx[2], tx[3]};
        for (int i = 4; i < n; i++) begin
          exp_en[i] = 1'b1;
          exp_rx[i] = m_mem[(a + i - 4) % MB];
        end
      end
      8'h02: if (n >= 4) begin
        a = {8'h00, tx[1], tx[2], tx[3]};
        if (m_wel) begin
          for (int i = 4; i < n; i++) m_mem[(a + i - 4) % MB] = tx[i];
          m_wel = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare(input string nm, input int n, input bytes8_t rx, input logic [7:0] ea,
                         input logic [7:0] eall, input bytes8_t exp_rx, input logic [7:0] exp_en);
    for (int i = 0; i < n; i++) begin
      check({nm, "_rx"}, i, rx[i], exp_rx[i]);
      check({nm, "_en"}, i, {6'b0, ea[i], eall[i]}, exp_en[i] ? 8'h03 : 8'h00);
    end
  endtask

  task automatic model_check(input string nm, input bytes8_t tx, input int n);
    bytes8_t rx, erx;
    logic [7:0] ea, eall, een;
    model_txn(tx, n, erx, een);
    do_txn(tx, n, rx, ea, eall);
    compare(nm, n, rx, ea, eall, erx, een);
    check({nm, "_wel"}, 0, {7'b0, wel}, {7'b0, m_wel});
  endtask

  function automatic vec_t mkv(input string nm, input logic [63:0] tx, input int n,
                               input logic [63:0] rx, input logic [7:0] en, input logic w);
    vec_t v;
    v.name = nm; v.tx = tx; v.n = n; v.rx = rx; v.en = en; v.wel = w;
    return v;
  endfunction

  initial begin
    vec_t       vt [11];
    bytes8_t    rx, erx, tx;
    logic [7:0] ea, eall, een, r;
    logic       a, b;
    int         sel, n;

    vt[0]  = mkv("jedec",   64'h9F00000000000000, 5, 64'h00EF4016FF000000, 8'h1E, 1'b0);
    vt[1]  = mkv("rd_wrap", 64'h030000FE00000000, 8, 64'h00000000FEFF0001, 8'hF0, 1'b0);
    vt[2]  = mkv("rd_hiad", 64'h03AB00FE00000000, 8, 64'h00000000FEFF0001, 8'hF0, 1'b0);
    vt[3]  = mkv("wren",    64'h0600000000000000, 1, 64'h0,                8'h00, 1'b1);
    vt[4]  = mkv("stat_we", 64'h0500000000000000, 2, 64'h0002000000000000, 8'h02, 1'b1);
    vt[5]  = mkv("prog",    64'h02000010A55A0000, 6, 64'h0,                8'h00, 1'b0);
    vt[6]  = mkv("rd_back", 64'h0300001000000000, 6, 64'h00000000A55A0000, 8'h30, 1'b0);
    vt[7]  = mkv("prog_nw", 64'h0200002077000000, 5, 64'h0,                8'h00, 1'b0);
    vt[8]  = mkv("rd_20",   64'h0300002000000000, 5, 64'h0000000020000000, 8'h10, 1'b0);
    vt[9]  = mkv("stat_0",  64'h0500000000000000, 2, 64'h0,                8'h02, 1'b0);
    vt[10] = mkv("unknown", 64'hAB00000000000000, 3, 64'h0,                8'h00, 1'b0);

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; copi = 1'b0;
    load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
    m_wel = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_cipo", 0, {7'b0, cipo}, 8'h00);
    check("rst_en",   0, {7'b0, cipo_en}, 8'h00);
    check("rst_wel",  0, {7'b0, wel}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < MB; i++) begin
      load_en = 1'b1; load_addr = 8'(i); load_data = 8'(i);
      m_mem[i] = 8'(i);
      @(negedge clk);
    end
    load_en = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      do_txn(vt[v].tx, vt[v].n, rx, ea, eall);
      compare(vt[v].name, vt[v].n, rx, ea, eall, vt[v].rx, vt[v].en);
      check({vt[v].name, "_wel"}, v, {7'b0, wel}, {7'b0, vt[v].wel});
      model_txn(vt[v].tx, vt[v].n, erx, een);
    end

    // PROG data byte cut after 5 bits: nothing written, WEL still cleared.
    model_check("ab_wren", 64'h0600000000000000, 1);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    tx = 64'h0200003000000000;
    for (int i = 0; i < 4; i++) spi_bits(tx[i], 8, r, a, b);
    spi_bits(8'hC3, 5, r, a, b);
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    m_wel = 1'b0;
    check("ab_wel", 0, {7'b0, wel}, 8'h00);
    model_check("ab_rd", 64'h0300003000000000, 5);

    // Reset in the middle of a read byte.
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    tx = 64'h0300000000000000;
    for (int i = 0; i < 4; i++) spi_bits(tx[i], 8, r, a, b);
    spi_bits(8'h00, 3, r, a, b);
    check("pre_rst_en", 0, {7'b0, cipo_en}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_en",   0, {7'b0, cipo_en}, 8'h00);
    check("mid_rst_cipo", 0, {7'b0, cipo}, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    m_wel = 1'b0;
    model_check("post_rst_jedec", 64'h9F00000000000000, 5);

    // Random transactions against the model.
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 9);
      tx = {$urandom, $urandom};
      case (sel)
        0, 1: begin tx[0] = 8'h03; n = 4 + $urandom_range(0, 4); end
        2, 3: begin tx[0] = 8'h02; n = 4 + $urandom_range(0, 4); end
        4:    begin tx[0] = 8'h05; n = 1 + $urandom_range(1, 4); end
        5:    begin tx[0] = 8'h9F; n = 1 + $urandom_range(1, 4); end
        6, 7: begin tx[0] = 8'h06; n = 1; end
        8:    begin tx[0] = 8'h04; n = 1; end
        default: begin
          if (tx[0] inside {8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h9F}) tx[0] = 8'hAB;
          n = 1 + $urandom_range(0, 3);
        end
      endcase
      model_check("rand", tx, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI-flash responder: the device end of the SPI host link that drives the application flash (mode 0, single-bit COPI/CIPO, active-low chip select). It decodes a small JEDEC-style command subset and serves reads and programs from an internal byte array. It sits on the board-side SPI pins in simulation tops, alongside or instead of the flash SPI DPI model, so that flash traffic can be checked in pure RTL.

## Interface

Parameters:

- MemBytes, 256: size of the internal byte array; power of two, at least 4; AW = $clog2(MemBytes).
- JedecId, 24'hEF4016: manufacturer/type/capacity bytes returned by 0x9F, MSB first.

Ports:

- clk_i  input  1  system clock; SPI pins are oversampled on it.
- rst_i  input  1  synchronous, active-high reset.
- sck_i  input  1  SPI clock, asynchronous to clk_i.
- cs_ni  input  1  chip select, active low, asynchronous.
- copi_i  input  1  controller-out data, asynchronous.
- cipo_o  output  1  controller-in data.
- cipo_en_o  output  1  high while the responder actively drives cipo_o.
- wel_o  output  1  write-enable latch.
- load_en_i  input  1  backdoor write strobe.
- load_addr_i  input  AW  backdoor address.
- load_data_i  input  8  backdoor data.

## Operation

- **Synchronization:** sck_i, cs_ni and copi_i each pass through a 2-flop synchronizer. One further register detects rising and falling edges of the synchronized sck. In the rest of this spec, "rise", "fall" and "cs" always mean the synchronized versions.
- **Bit transfer:** on each rise while cs is low, shift copi into an 8-bit shift register, MSB first; a 3-bit counter marks byte completion. On each fall, shift the next response bit onto cipo_o.
- **States and transitions:**
  - IDLE: entered on cs high.
  - CMD: collects the command byte. When it completes:
    - 0x03 -> ADDR(read).
    - 0x02 -> ADDR(prog).
    - 0x05 -> STATUS.
    - 0x9F -> JEDEC.
    - 0x06 -> set WEL, then IGNORE.
    - 0x04 -> clear WEL, then IGNORE.
    - any other byte -> IGNORE.
  - ADDR: collects 3 address bytes, MSB first. Only the low AW bits are kept; upper bits are ignored. Then goes to READ or PROG.
  - READ: outputs mem[addr]. After each 8th bit, addr = (addr+1) mod MemBytes.
  - PROG: on each completed byte, if WEL is set, write mem[addr] and increment addr mod MemBytes. If WEL is clear, discard the byte.
  - STATUS: repeatedly returns {6'b0, wel, 1'b0}.
  - JEDEC: returns the three JedecId bytes, then 8'hFF for every following byte.
  - IGNORE: cipo_en_o = 0 until cs goes high.
- **Output enable:** cipo_en_o = 1 only in READ, STATUS and JEDEC. Elsewhere cipo_o = 0.
- **Response MSB:** the first response bit is driven on the fall that follows the rise sampling the last command or address bit.
- **cs deassertion:**
  - cs high at any point returns to IDLE, clears the bit counter and drops cipo_en_o.
  - A partial byte is discarded; in PROG it is never written.
  - If a PROG transaction had WEL set on entry, WEL clears when cs goes high, even if no data byte was written.
- **Backdoor load:** load_en_i writes mem[load_addr_i] in the same cycle. If it coincides with a PROG write to the same address, the load wins.
- **Reset values:**
  - State = IDLE; WEL = 0; bit counter = 0.
  - cipo_o = 0; cipo_en_o = 0; wel_o = 0.
  - Array contents are not reset; zero-initialized in simulation.
  - Reset mid-transaction aborts it; the host must toggle cs before the next command.

## Timing

- Pin-to-edge-detect latency is 3 clk_i cycles.
- sck high and low phases must each last at least 4 clk_i cycles. The cs setup and hold around the first and last sck edge must be at least 4 clk_i cycles.
- cipo_o and cipo_en_o are registered. cipo_o updates 1 cycle after fall detection, i.e. 4 clk_i cycles after the sck_i pin falls.
- Array write occurs 1 cycle after the rise that completes the byte.
- WEL update:
  - WREN/WRDI: 1 cycle after the command byte completes.
  - PROG clear: 1 cycle after cs high is detected.
- Read data for byte N+1 is fetched during byte N, so there are no wait bytes between consecutive read bytes.

## Test plan

- **JEDEC ID:** 0x9F followed by 4 dummy bytes -> CIPO returns EF 40 16 FF; cipo_en_o is high only after the command byte.
- **Read with wrap:** preload via backdoor mem[i] = i; 0x03 with address 0x0000FE, read 4 bytes -> FE FF 00 01 (MemBytes = 256). The address 0xAB00FE gives the same result.
- **Program then read back:**
  - 0x06; 0x05 -> status 0x02.
  - 0x02 with address 0x000010, then data A5 5A; raise cs -> wel_o = 0.
  - 0x03 with address 0x000010 -> A5 5A.
- **Program without WEL:** 0x02 with address 0x20, data 77 -> mem[0x20] unchanged; status reads 0x00.
- **Abort:** raise cs after 5 bits of a PROG data byte -> no write occurs. An unknown command 0xAB -> cipo_en_o stays 0 for the whole transaction.
- **Reset mid-READ:** assert rst_i during a read byte -> cipo_en_o = 0 next cycle. After cs toggles, 0x9F works normally.
